// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the 8-bit FIFO read port and serialises each
// as an async UART frame on tx (start bit, 8 data bits LSB first, 1 or 2 stop
// bits). Every output is a flop fed from next-state logic, so nothing on the
// input side reaches an output pin combinationally.
//
// Handshake: rd_en is a one-cycle pop request issued in FETCH only when the
// FIFO reported non-empty in the deciding cycle (IDLE or last STOP cycle);
// the FIFO answers with buf_out valid in the following cycle (LOAD), where
// it is captured. There is no back-pressure on the read port.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buf_empty,
    input  logic [7:0] buf_out,
    output logic       rd_en,
    input  logic       tx_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       frame_done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shift, shift_d;
    logic             tx_d;
    logic             last_cnt;
    logic             can_start;

    assign dbg_state = state;
    assign last_cnt  = (cnt == CNT_LAST);
    assign can_start = tx_en && !buf_empty;

    // Next-state, baud counter, bit index and shift register update.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        case (state)
            IDLE: begin
                if (can_start) state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = buf_out;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = can_start ? FETCH : IDLE;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from the next state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State and registered outputs; reset drops any popped byte and idles the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            rd_en      <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_d;
            shift      <= shift_d;
            tx         <= tx_d;
            rd_en      <= (state_d == FETCH);
            tx_busy    <= (state_d != IDLE);
            frame_done <= (state_d == STOP) && (cnt_d == CNT_LAST) && (bit_d == STOP_LAST);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model plus two transmitters (1 and 2 stop bits); a
// select line routes the FIFO to one of them, the other sees an empty FIFO.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en;
    logic       sel;
    int         stop_bits;

    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         underflow = 0;
    logic [7:0] buf_out = 8'h00;
    logic       buf_empty_f;

    logic       rd_en1, tx1, tx_busy1, frame_done1;
    logic       rd_en2, tx2, tx_busy2, frame_done2;
    logic [2:0] dbg_state1, dbg_state2;
    logic       buf_empty1, buf_empty2, tx_en1, tx_en2;
    logic       rd_en_m, tx_m, tx_busy_m, frame_done_m;
    logic [2:0] dbg_state_m;

    logic [7:0] exp_q [$];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign buf_empty_f  = (wr_ptr == rd_ptr);
    assign buf_empty1   = sel ? 1'b1 : buf_empty_f;
    assign buf_empty2   = sel ? buf_empty_f : 1'b1;
    assign tx_en1       = sel ? 1'b0 : tx_en;
    assign tx_en2       = sel ? tx_en : 1'b0;
    assign rd_en_m      = sel ? rd_en2 : rd_en1;
    assign tx_m         = sel ? tx2 : tx1;
    assign tx_busy_m    = sel ? tx_busy2 : tx_busy1;
    assign frame_done_m = sel ? frame_done2 : frame_done1;
    assign dbg_state_m  = sel ? dbg_state2 : dbg_state1;

    // FIFO read port: data appears the cycle after rd_en is sampled.
    always @(posedge clk) begin
        if (rd_en_m) begin
            if (wr_ptr == rd_ptr) begin
                underflow <= underflow + 1;
            end else begin
                buf_out <= mem[rd_ptr[3:0]];
                rd_ptr  <= rd_ptr + 1;
            end
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .buf_empty(buf_empty1), .buf_out(buf_out),
        .rd_en(rd_en1), .tx_en(tx_en1), .tx(tx1), .tx_busy(tx_busy1),
        .frame_done(frame_done1), .dbg_state(dbg_state1)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .buf_empty(buf_empty2), .buf_out(buf_out),
        .rd_en(rd_en2), .tx_en(tx_en2), .tx(tx2), .tx_busy(tx_busy2),
        .frame_done(frame_done2), .dbg_state(dbg_state2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Waits (bounded) for a pop request; t is the cycle stamp or -1.
    task automatic wait_rd_en(input string tag, output int t);
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd_en_m === 1'b1) begin
                t = cyc;
                break;
            end
        end
        chk({tag, "_rd_en_seen"}, 32'(t >= 0), 32'(1));
    endtask

    // Called on the FETCH cycle; walks the whole frame against the popped byte.
    task automatic check_frame(input string tag, input int drop_at);
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       exp_tx;
        int         bad;
        int         fd_cnt;
        int         n;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'(1));
        exp_b  = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        got    = 8'h00;
        bad    = 0;
        fd_cnt = 0;
        if (tx_m !== 1'b1 || tx_busy_m !== 1'b1) bad++;
        @(negedge clk);
        if (tx_m !== 1'b1 || rd_en_m !== 1'b0 || tx_busy_m !== 1'b1) bad++;
        n = (9 + stop_bits) * CPB;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < CPB)          exp_tx = 1'b0;
            else if (k < 9 * CPB) exp_tx = exp_b[k / CPB - 1];
            else                  exp_tx = 1'b1;
            if (tx_m !== exp_tx || frame_done_m !== (k == n - 1) ||
                tx_busy_m !== 1'b1 || rd_en_m !== 1'b0) bad++;
            if (frame_done_m === 1'b1) fd_cnt++;
            if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2) got[k / CPB - 1] = tx_m;
            if (k == drop_at) tx_en = 1'b0;
        end
        chk({tag, "_byte"}, 32'(got), 32'(exp_b));
        chk({tag, "_bad_cycles"}, 32'(bad), 32'(0));
        chk({tag, "_frame_done_cnt"}, 32'(fd_cnt), 32'(1));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0, t1, t2, errs;
        logic [7:0] dropped;
        rst_n     = 1'b0;
        tx_en     = 1'b0;
        sel       = 1'b0;
        stop_bits = 1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_m), 32'(1));
        chk("rst_rd_en", 32'(rd_en_m), 32'(0));
        chk("rst_busy", 32'(tx_busy_m), 32'(0));
        chk("rst_done", 32'(frame_done_m), 32'(0));
        chk("rst_state", 32'(dbg_state_m), 32'(0));
        rst_n = 1'b1;
        tx_en = 1'b1;

        // Empty FIFO with tx_en high: nothing moves
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_en_m !== 1'b0 || tx_m !== 1'b1 || tx_busy_m !== 1'b0) errs++;
        end
        chk("empty_idle_errs", 32'(errs), 32'(0));

        // Single byte 0xA5
        push_byte(8'hA5);
        wait_rd_en("t1", t0);
        check_frame("t1", -1);
        @(negedge clk);
        chk("t1_idle_state", 32'(dbg_state_m), 32'(0));
        chk("t1_fifo_empty", 32'(buf_empty_f), 32'(1));
        chk("t1_busy_low", 32'(tx_busy_m), 32'(0));

        // Back-to-back frames
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        wait_rd_en("t2a", t0);
        check_frame("t2a", -1);
        wait_rd_en("t2b", t1);
        chk("t2_period_ab", 32'(t1 - t0), 32'((9 + 1) * CPB + 2));
        check_frame("t2b", -1);
        wait_rd_en("t2c", t2);
        chk("t2_period_bc", 32'(t2 - t1), 32'((9 + 1) * CPB + 2));
        check_frame("t2c", -1);
        @(negedge clk);
        chk("t2_idle_state", 32'(dbg_state_m), 32'(0));

        // tx_en dropped during data bit 3
        push_byte(8'h96);
        push_byte(8'h69);
        wait_rd_en("t4a", t0);
        check_frame("t4a", CPB * 4 + 1);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_en_m !== 1'b0) errs++;
        end
        chk("t4_no_second_pop", 32'(errs), 32'(0));
        chk("t4_held_idle", 32'(dbg_state_m), 32'(0));
        chk("t4_fifo_not_empty", 32'(buf_empty_f), 32'(0));
        tx_en = 1'b1;
        @(negedge clk);
        chk("t4_restart_fetch", 32'(rd_en_m), 32'(1));
        check_frame("t4b", -1);

        // Reset during data bit 5 of the first frame
        push_byte(8'h3C);
        push_byte(8'h81);
        wait_rd_en("t5a", t0);
        dropped = exp_q.pop_front();
        repeat (CPB * 6 + 2) @(negedge clk);
        chk("t5_busy_before_rst", 32'(tx_busy_m), 32'(1));
        chk("t5_tx_bit5", 32'(tx_m), 32'(dropped[5]));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", 32'(tx_m), 32'(1));
        chk("t5_rst_rd_en", 32'(rd_en_m), 32'(0));
        chk("t5_rst_busy", 32'(tx_busy_m), 32'(0));
        chk("t5_rst_state", 32'(dbg_state_m), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_rd_en("t5b", t1);
        check_frame("t5b", -1);

        // Two stop bits
        @(negedge clk);
        sel       = 1'b1;
        stop_bits = 2;
        push_byte(8'hC3);
        push_byte(8'h18);
        wait_rd_en("t6a", t0);
        check_frame("t6a", -1);
        wait_rd_en("t6b", t1);
        chk("t6_period", 32'(t1 - t0), 32'((9 + 2) * CPB + 2));
        check_frame("t6b", -1);
        @(negedge clk);
        chk("t6_idle_state", 32'(dbg_state_m), 32'(0));

        chk("no_underflow", 32'(underflow), 32'(0));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
